// File: rtl/ap_pass_sequencer.sv
// Bit-serial compare/write pass sequencer for the associative processor CAM/tag array.
// Optional performance counters are enabled with `define AP_SEQ_PERF_EN.
module ap_pass_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [$clog2(DATA_WIDTH):0]   cmd_width,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_idx,
  output logic                          cmp_en,
  output logic [2:0]                    key,
  output logic [2:0]                    key_mask,
  output logic                          wr_en,
  output logic [1:0]                    wr_val,
  output logic [1:0]                    wr_mask,
  output logic                          busy,
  output logic                          done,
  output logic                          err
`ifdef AP_SEQ_PERF_EN
  ,
  output logic [31:0]                   perf_cycles,
  output logic [15:0]                   perf_cmds
`endif
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam int WW = IW + 1;
  localparam logic [WW-1:0] MAX_W     = WW'(DATA_WIDTH);
  localparam logic [1:0]    WAIT_LAST = 2'((TAG_LAT >= 2) ? (TAG_LAT - 2) : 0);

  typedef enum logic [2:0] {IDLE, CMP, WAIT, WR, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_COPY = 2'b01, OP_AND = 2'b10, OP_RSVD = 2'b11} op_t;

  state_t         state, state_d;
  op_t            op_q, op_d;
  logic [WW-1:0]  width_q, width_d;
  logic [IW-1:0]  bit_q, bit_d;
  logic [1:0]     pass_q, pass_d;
  logic [1:0]     wait_q, wait_d;
  logic           pre_q, pre_d;
  logic           err_q, err_d;

  logic [1:0]     pass_max;
  logic           last_pass;
  logic           last_bit;
  logic           cmd_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= OP_ADD;
      width_q <= '0;
      bit_q   <= '0;
      pass_q  <= '0;
      wait_q  <= '0;
      pre_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      width_q <= width_d;
      bit_q   <= bit_d;
      pass_q  <= pass_d;
      wait_q  <= wait_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    op_d    = op_q;
    width_d = width_q;
    bit_d   = bit_q;
    pass_d  = pass_q;
    wait_d  = wait_q;
    pre_d   = pre_q;
    err_d   = err_q;

    case (op_q)
      OP_ADD:  pass_max = 2'd3;
      OP_COPY: pass_max = 2'd1;
      default: pass_max = 2'd0;
    endcase
    last_pass = (pass_q == pass_max);
    last_bit  = ({1'b0, bit_q} == (width_q - 1'b1));
    cmd_bad   = (cmd_op == OP_RSVD) || (cmd_width == '0) || (cmd_width > MAX_W);

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          width_d = cmd_width;
          bit_d   = '0;
          pass_d  = '0;
          wait_d  = '0;
          err_d   = cmd_bad;
          pre_d   = !cmd_bad && (cmd_op == OP_ADD);
          state_d = cmd_bad ? DONE : CMP;
        end
      end
      CMP: begin
        wait_d  = '0;
        state_d = (TAG_LAT == 1) ? WR : WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) state_d = WR;
        else                     wait_d  = wait_q + 2'd1;
      end
      WR: begin
        // The ADD carry-clear preamble is an extra pass in bit 0 and does not advance the pass index.
        if (pre_q) begin
          pre_d   = 1'b0;
          state_d = CMP;
        end else if (!last_pass) begin
          pass_d  = pass_q + 2'd1;
          state_d = CMP;
        end else begin
          pass_d = '0;
          if (last_bit) begin
            bit_d   = '0;
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = CMP;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    cmp_en    = (state == CMP);
    wr_en     = (state == WR);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    bit_idx   = bit_q;
    key       = '0;
    key_mask  = '0;
    wr_val    = '0;
    wr_mask   = '0;

    if (state == CMP || state == WAIT || state == WR) begin
      if (pre_q) begin
        wr_mask = 2'b10;
      end else begin
        case (op_q)
          OP_ADD: begin
            key_mask = '1;
            wr_mask  = '1;
            case (pass_q)
              2'd0:    begin key = 3'b011; wr_val = 2'b10; end
              2'd1:    begin key = 3'b001; wr_val = 2'b01; end
              2'd2:    begin key = 3'b100; wr_val = 2'b01; end
              default: begin key = 3'b110; wr_val = 2'b10; end
            endcase
          end
          OP_COPY: begin
            key_mask = 3'b011;
            wr_mask  = 2'b01;
            if (pass_q == 2'd0) begin key = 3'b001; wr_val = 2'b01; end
            else                begin key = 3'b010; wr_val = 2'b00; end
          end
          OP_AND: begin
            key_mask = 3'b011;
            wr_mask  = 2'b01;
            key      = 3'b010;
            wr_val   = 2'b00;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef AP_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_cmds   <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
      if (done && !err_q)              perf_cmds   <= perf_cmds + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ap_pass_sequencer.sv
// Self-checking bench: drives commands into two sequencers (TAG_LAT 1 and 3) and
// applies their passes to a behavioural CAM array, checking results arithmetically.
module tb_ap_pass_sequencer;

  localparam int DW    = 16;
  localparam int IW    = $clog2(DW);
  localparam int WW    = IW + 1;
  localparam int NROWS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [WW-1:0] cmd_width;
  logic          cv1, cv3;
  assign cv1 = cmd_valid & ~sel;
  assign cv3 = cmd_valid & sel;

  logic          rdy1, cmp1, wr1, busy1, done1, err1;
  logic          rdy3, cmp3, wr3, busy3, done3, err3;
  logic [IW-1:0] bit1, bit3;
  logic [2:0]    key1, km1, key3, km3;
  logic [1:0]    wv1, wm1, wv3, wm3;

  ap_pass_sequencer #(.DATA_WIDTH(DW), .TAG_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_op(cmd_op),
    .cmd_width(cmd_width), .bit_idx(bit1), .cmp_en(cmp1), .key(key1), .key_mask(km1),
    .wr_en(wr1), .wr_val(wv1), .wr_mask(wm1), .busy(busy1), .done(done1), .err(err1));

  ap_pass_sequencer #(.DATA_WIDTH(DW), .TAG_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cv3), .cmd_ready(rdy3), .cmd_op(cmd_op),
    .cmd_width(cmd_width), .bit_idx(bit3), .cmp_en(cmp3), .key(key3), .key_mask(km3),
    .wr_en(wr3), .wr_val(wv3), .wr_mask(wm3), .busy(busy3), .done(done3), .err(err3));

  logic          rdy, cmpe, wre, bsy, dn, er;
  logic [IW-1:0] bidx;
  logic [2:0]    key, km;
  logic [1:0]    wv, wm;
  assign rdy  = sel ? rdy3  : rdy1;
  assign cmpe = sel ? cmp3  : cmp1;
  assign wre  = sel ? wr3   : wr1;
  assign bsy  = sel ? busy3 : busy1;
  assign dn   = sel ? done3 : done1;
  assign er   = sel ? err3  : err1;
  assign bidx = sel ? bit3  : bit1;
  assign key  = sel ? key3  : key1;
  assign km   = sel ? km3   : km1;
  assign wv   = sel ? wv3   : wv1;
  assign wm   = sel ? wm3   : wm1;

  // Behavioural CAM array: A and B words plus one carry bit per row.
  logic [DW-1:0] ma [NROWS];
  logic [DW-1:0] mb [NROWS];
  logic          mc [NROWS];
  logic          tag[NROWS];

  int errors = 0;
  int checks = 0;

  // First compare/write seen in the most recent command.
  logic [2:0] fk, fkm;
  logic [1:0] fwv, fwm;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic run_cmd(input int op, input int w, input bit hold, input bit ex);
    int lat, passes, exp_done, k, ncmp, nwr, last_cmp, eb;
    bit legal, got_done;
    logic [2:0] cap_key, cap_km;
    logic [DW-1:0] a0 [NROWS];
    logic [DW-1:0] b0 [NROWS];
    logic          c0 [NROWS];
    logic [31:0] msk, sum, exp_b, exp_c;
    logic [2:0]  cba;

    lat      = sel ? 3 : 1;
    legal    = (op != 3) && (w >= 1) && (w <= DW);
    passes   = !legal ? 0 : (op == 0) ? 1 + 4 * w : (op == 1) ? 2 * w : w;
    exp_done = legal ? 1 + passes * (lat + 1) : 1;

    for (int r = 0; r < NROWS; r++) begin
      ma[r] = DW'($urandom);
      mb[r] = DW'($urandom);
      mc[r] = 1'($urandom);
    end
    if (ex) begin
      ma[0] = 16'h0007;
      mb[0] = 16'h0003;
    end
    for (int r = 0; r < NROWS; r++) begin
      a0[r] = ma[r]; b0[r] = mb[r]; c0[r] = mc[r];
    end

    check("accept_ready", 32'(rdy), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_width = WW'(w);
    k = 0; ncmp = 0; nwr = 0; last_cmp = -100; got_done = 1'b0;
    cap_key = '0; cap_km = '0;

    while (!got_done && k < 600) begin
      @(posedge clk); #1;
      if (hold) begin
        cmd_op    = 2'($urandom);
        cmd_width = WW'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      k++;
      check("busy", 32'(bsy), 32'd1);
      check("ready_busy", 32'(rdy), 32'd0);
      if (cmpe) begin
        case (op)
          0:       eb = (ncmp == 0) ? 0 : (ncmp - 1) / 4;
          1:       eb = ncmp / 2;
          default: eb = ncmp;
        endcase
        check("cmp_bit", 32'(bidx), 32'(eb));
        if (ncmp == 0) begin fk = key; fkm = km; end
        for (int r = 0; r < NROWS; r++) begin
          cba    = {mc[r], mb[r][bidx], ma[r][bidx]};
          tag[r] = (((cba ^ key) & km) == 3'b000);
        end
        cap_key  = key;
        cap_km   = km;
        last_cmp = k;
        ncmp++;
      end
      if (wre) begin
        check("wr_lat", 32'(k - last_cmp), 32'(lat));
        check("key_hold", 32'({key, km}), 32'({cap_key, cap_km}));
        if (nwr == 0) begin fwv = wv; fwm = wm; end
        for (int r = 0; r < NROWS; r++) begin
          if (tag[r]) begin
            if (wm[1]) mc[r] = wv[1];
            if (wm[0]) mb[r][bidx] = wv[0];
          end
        end
        nwr++;
      end
      if (dn) begin
        got_done = 1'b1;
        check("done_cycle", 32'(k), 32'(exp_done));
        check("err", 32'(er), 32'(!legal));
        check("passes", 32'(ncmp), 32'(passes));
        check("writes", 32'(nwr), 32'(passes));
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);

    @(negedge clk);
    check("ready_after_done", 32'(rdy), 32'd1);
    check("done_pulse", 32'(dn), 32'd0);
    check("bit_idle", 32'(bidx), 32'd0);

    if (legal) begin
      msk = (32'd1 << w) - 32'd1;
      for (int r = 0; r < NROWS; r++) begin
        case (op)
          0: begin
            sum   = (32'(a0[r]) & msk) + (32'(b0[r]) & msk);
            exp_b = (32'(b0[r]) & ~msk) | (sum & msk);
            exp_c = (sum >> w) & 32'd1;
          end
          1: begin
            exp_b = (32'(b0[r]) & ~msk) | (32'(a0[r]) & msk);
            exp_c = 32'(c0[r]);
          end
          default: begin
            exp_b = 32'(b0[r]) & (32'(a0[r]) | ~msk);
            exp_c = 32'(c0[r]);
          end
        endcase
        check("result_b", 32'(mb[r]), exp_b & 32'hFFFF);
        check("result_c", 32'(mc[r]), exp_c);
      end
    end
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_width = '0;
    fk = '0; fkm = '0; fwv = '0; fwm = '0;
    repeat (3) @(negedge clk);
    check("reset_outs_dut1", 32'({rdy1, busy1, cmp1, wr1, done1, err1, key1, km1, wv1, wm1, bit1}), 32'h80000);
    check("reset_outs_dut3", 32'({rdy3, busy3, cmp3, wr3, done3, err3, key3, km3, wv3, wm3, bit3}), 32'h80000);
    rst = 1'b1;
    @(negedge clk);

    // Abandon an ADD at cycle 10 with an asynchronous reset.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_width = WW'(16);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midadd_busy", 32'(busy1), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset_outs", 32'({rdy1, busy1, cmp1, wr1, done1, err1, key1, km1, wv1, wm1, bit1}), 32'h80000);
    repeat (3) begin
      @(negedge clk);
      check("midreset_hold", 32'({rdy1, busy1, cmp1, wr1, done1, err1, key1, km1, wv1, wm1, bit1}), 32'h80000);
    end
    rst = 1'b1;

    run_cmd(0, 16, 1'b0, 1'b0);

    run_cmd(0, 4, 1'b0, 1'b1);
    check("add_example_b", 32'(mb[0][3:0]), 32'hA);
    check("add_example_c", 32'(mc[0]), 32'd0);

    sel = 1'b1;
    run_cmd(1, 16, 1'b0, 1'b0);
    sel = 1'b0;

    run_cmd(2, 1, 1'b0, 1'b0);
    check("and_key", 32'(fk[1:0]), 32'h2);
    check("and_key_mask", 32'(fkm), 32'h3);
    check("and_wr_val", 32'(fwv[0]), 32'd0);
    check("and_wr_mask", 32'(fwm), 32'h1);

    run_cmd(3, 4, 1'b0, 1'b0);
    run_cmd(0, 0, 1'b0, 1'b0);
    run_cmd(1, 17, 1'b0, 1'b0);

    // cmd_valid held high with junk inputs while busy.
    for (int i = 0; i < 6; i++)
      run_cmd($urandom_range(0, 2), $urandom_range(1, DW), 1'b1, 1'b0);
    run_cmd(2, DW, 1'b1, 1'b0);
    cmd_valid = 1'b0;

    sel = 1'b1;
    for (int i = 0; i < 4; i++)
      run_cmd($urandom_range(0, 2), $urandom_range(1, DW), 1'b1, 1'b0);
    cmd_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sel = 1'($urandom);
      run_cmd($urandom_range(0, 3), $urandom_range(0, DW + 1), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
